// File: rtl/load_store_unit_if.sv
// Core/memory-facing bundle of the load/store unit.
// slave is the LSU side, master is the core plus data-memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        fault;
    logic        fault_sticky;
    logic        fault_clr;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] mem_read_data;

    modport master (
        output req_valid,
        output req_write,
        output req_funct3,
        output req_addr,
        output req_wdata,
        output fault_clr,
        output mem_read_data,
        input  stall,
        input  load_data,
        input  load_valid,
        input  fault,
        input  fault_sticky,
        input  mem_addr,
        input  mem_write_data,
        input  mem_write,
        input  mem_read
    );

    modport slave (
        input  req_valid,
        input  req_write,
        input  req_funct3,
        input  req_addr,
        input  req_wdata,
        input  fault_clr,
        input  mem_read_data,
        output stall,
        output load_data,
        output load_valid,
        output fault,
        output fault_sticky,
        output mem_addr,
        output mem_write_data,
        output mem_write,
        output mem_read
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: decode, fault check, load lane extension,
// and a two-cycle read-modify-write for SB/SH on a word-only memory.
module load_store_unit #(
    parameter int unsigned MEM_BYTES   = 1024,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    load_store_unit_if.slave bus
);

    // The read half of the RMW is the IDLE cycle that issues it,
    // so only the write half needs its own state.
    typedef enum logic {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:0] rmw_addr;
    logic [15:0] rmw_data;
    logic [2:0]  rmw_f3;
    logic [31:0] merge_q;
    logic        fault_sticky_q;

    logic        f3_b;
    logic        f3_h;
    logic        f3_w;
    logic [1:0]  size_m1;
    logic [32:0] last_byte;
    logic        illegal;
    logic        misalign;
    logic        out_of_range;
    logic        access;
    logic        fault_now;
    logic        do_load;
    logic        do_sw;
    logic        do_rmw;
    logic [31:0] req_word_addr;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    // Request decode and fault classification.
    always_comb begin
        f3_b = (bus.req_funct3[1:0] == 2'b00);
        f3_h = (bus.req_funct3[1:0] == 2'b01);
        f3_w = (bus.req_funct3[1:0] == 2'b10);
        size_m1 = f3_b ? 2'd0 : (f3_h ? 2'd1 : 2'd3);
        // 33-bit sum keeps addresses near 2^32 from wrapping into range.
        last_byte = {1'b0, bus.req_addr} + {31'd0, size_m1};
        out_of_range = (last_byte >= 33'(MEM_BYTES));
        if (bus.req_write) begin
            illegal = bus.req_funct3[2] | (&bus.req_funct3[1:0]);
        end else begin
            illegal = (&bus.req_funct3[1:0])
                    | (bus.req_funct3[2] & bus.req_funct3[1]);
        end
        misalign = CHECK_ALIGN
                 && ((f3_h && bus.req_addr[0])
                 || (f3_w && (bus.req_addr[1:0] != 2'b00)));
        access = rst_n && (state == IDLE) && bus.req_valid;
        fault_now = access && (illegal || misalign || out_of_range);
        do_load = access && !fault_now && !bus.req_write;
        do_sw = access && !fault_now && bus.req_write && f3_w;
        do_rmw = access && !fault_now && bus.req_write && !f3_w;
        req_word_addr = {bus.req_addr[31:2], 2'b00};
    end

    // Select the addressed lane and sign/zero-extend it.
    always_comb begin
        ld_byte = 8'h00;
        unique case (bus.req_addr[1:0])
            2'd0: ld_byte = bus.mem_read_data[7:0];
            2'd1: ld_byte = bus.mem_read_data[15:8];
            2'd2: ld_byte = bus.mem_read_data[23:16];
            2'd3: ld_byte = bus.mem_read_data[31:24];
        endcase
        ld_half = bus.req_addr[1] ? bus.mem_read_data[31:16]
                                  : bus.mem_read_data[15:0];
        ld_ext = 32'h0;
        unique case (bus.req_funct3)
            3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
            3'b010:  ld_ext = bus.mem_read_data;
            3'b100:  ld_ext = {24'h0, ld_byte};
            3'b101:  ld_ext = {16'h0, ld_half};
            default: ld_ext = 32'h0;
        endcase
    end

    // Splice the captured store byte/half into the captured word.
    always_comb begin
        merged = merge_q;
        unique case (rmw_f3)
            3'b001: begin
                if (rmw_addr[1]) merged[31:16] = rmw_data;
                else             merged[15:0]  = rmw_data;
            end
            default: begin
                unique case (rmw_addr[1:0])
                    2'd0: merged[7:0]   = rmw_data[7:0];
                    2'd1: merged[15:8]  = rmw_data[7:0];
                    2'd2: merged[23:16] = rmw_data[7:0];
                    2'd3: merged[31:24] = rmw_data[7:0];
                endcase
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next state: a sub-word store always takes exactly one write cycle.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:      if (do_rmw) state_nx = RMW_WRITE;
            RMW_WRITE: state_nx = IDLE;
        endcase
    end

    // FSM outputs: everything is zero unless this cycle does something.
    always_comb begin
        bus.stall = 1'b0;
        bus.load_data = 32'h0;
        bus.load_valid = 1'b0;
        bus.fault = 1'b0;
        bus.mem_addr = 32'h0;
        bus.mem_write_data = 32'h0;
        bus.mem_write = 1'b0;
        bus.mem_read = 1'b0;
        unique case (state)
            IDLE: begin
                bus.fault = fault_now;
                bus.mem_read = do_load | do_rmw;
                bus.mem_write = do_sw;
                bus.stall = do_rmw;
                bus.load_valid = do_load;
                if (do_load) bus.load_data = ld_ext;
                if (do_sw) bus.mem_write_data = bus.req_wdata;
                if (do_load | do_sw | do_rmw) bus.mem_addr = req_word_addr;
            end
            RMW_WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr = {rmw_addr[31:2], 2'b00};
                bus.mem_write_data = merged;
            end
        endcase
    end

    // Capture the store and the old memory word during the read half.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rmw_addr <= 32'h0;
            rmw_data <= 16'h0;
            rmw_f3 <= 3'b000;
            merge_q <= 32'h0;
        end else if (do_rmw) begin
            rmw_addr <= bus.req_addr;
            rmw_data <= bus.req_wdata[15:0];
            rmw_f3 <= bus.req_funct3;
            merge_q <= bus.mem_read_data;
        end
    end

    // Sticky fault flag; a new fault beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             fault_sticky_q <= 1'b0;
        else if (fault_now)     fault_sticky_q <= 1'b1;
        else if (bus.fault_clr) fault_sticky_q <= 1'b0;
    end

    assign bus.fault_sticky = fault_sticky_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and random bench for load_store_unit with a byte-array
// reference model and a queue of expected load results.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    load_store_unit_if bus();

    load_store_unit #(
        .MEM_BYTES  (1024),
        .CHECK_ALIGN(1'b1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [7:0]  mem  [0:1023];
    logic [7:0]  refm [0:1023];
    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'h0;
    logic [31:0] pl_data = 32'h0;
    logic [31:0] sb_q [$];
    int          checks = 0;
    int          errors = 0;

    // Word-wide data memory: combinational read, write on posedge.
    assign bus.mem_read_data = {mem[{bus.mem_addr[9:2], 2'd3}],
                                mem[{bus.mem_addr[9:2], 2'd2}],
                                mem[{bus.mem_addr[9:2], 2'd1}],
                                mem[{bus.mem_addr[9:2], 2'd0}]};

    always @(posedge clk) begin
        if (bus.mem_write) begin
            mem[{bus.mem_addr[9:2], 2'd0}] <= bus.mem_write_data[7:0];
            mem[{bus.mem_addr[9:2], 2'd1}] <= bus.mem_write_data[15:8];
            mem[{bus.mem_addr[9:2], 2'd2}] <= bus.mem_write_data[23:16];
            mem[{bus.mem_addr[9:2], 2'd3}] <= bus.mem_write_data[31:24];
        end else if (pl_en) begin
            mem[{pl_addr[9:2], 2'd0}] <= pl_data[7:0];
            mem[{pl_addr[9:2], 2'd1}] <= pl_data[15:8];
            mem[{pl_addr[9:2], 2'd2}] <= pl_data[23:16];
            mem[{pl_addr[9:2], 2'd3}] <= pl_data[31:24];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] a);
        logic [9:0] w;
        w = {a[9:2], 2'b00};
        return {refm[w + 10'd3], refm[w + 10'd2],
                refm[w + 10'd1], refm[w]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3,
                                               input logic [31:0] a);
        logic [31:0] wd;
        logic [7:0]  b;
        logic [15:0] h;
        wd = model_word(a);
        b = refm[a[9:0]];
        h = {refm[{a[9:1], 1'b1}], refm[{a[9:1], 1'b0}]};
        case (f3)
            3'b000:  return 32'($signed(b));
            3'b001:  return 32'($signed(h));
            3'b010:  return wd;
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] f3, input logic [31:0] a,
                               input logic [31:0] d);
        refm[a[9:0]] = d[7:0];
        if (f3 != 3'b000) refm[a[9:0] + 10'd1] = d[15:8];
        if (f3 == 3'b010) begin
            refm[a[9:0] + 10'd2] = d[23:16];
            refm[a[9:0] + 10'd3] = d[31:24];
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] w);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = w;
        refm[{a[9:2], 2'd0}] = w[7:0];
        refm[{a[9:2], 2'd1}] = w[15:8];
        refm[{a[9:2], 2'd2}] = w[23:16];
        refm[{a[9:2], 2'd3}] = w[31:24];
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    task automatic drive(input logic v, input logic w, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_write = w;
        bus.req_funct3 = f3;
        bus.req_addr = a;
        bus.req_wdata = d;
    endtask

    task automatic do_idle();
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        #1;
        chk1("idle_stall", bus.stall, 1'b0);
        chk("idle_ld_data", bus.load_data, 32'h0);
        chk1("idle_mem_write", bus.mem_write, 1'b0);
    endtask

    task automatic do_load(input logic [2:0] f3, input logic [31:0] a,
                           output logic [31:0] obs);
        logic [31:0] e;
        @(negedge clk);
        drive(1'b1, 1'b0, f3, a, 32'h0);
        sb_q.push_back(model_load(f3, a));
        #1;
        chk1("ld_stall", bus.stall, 1'b0);
        chk1("ld_mem_read", bus.mem_read, 1'b1);
        chk1("ld_fault", bus.fault, 1'b0);
        chk("ld_mem_addr", bus.mem_addr, {a[31:2], 2'b00});
        chk1("ld_valid", bus.load_valid, 1'b1);
        obs = bus.load_data;
        if (bus.load_valid === 1'b1 && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk("ld_data", obs, e);
        end
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, output logic [31:0] wr);
        @(negedge clk);
        drive(1'b1, 1'b1, f3, a, d);
        #1;
        if (f3 == 3'b010) begin
            model_store(f3, a, d);
            chk1("sw_stall", bus.stall, 1'b0);
            chk1("sw_mem_write", bus.mem_write, 1'b1);
            chk("sw_data", bus.mem_write_data, d);
            chk("sw_addr", bus.mem_addr, {a[31:2], 2'b00});
            chk("sw_ld_data", bus.load_data, 32'h0);
            wr = bus.mem_write_data;
        end else begin
            chk1("rmw_rd_stall", bus.stall, 1'b1);
            chk1("rmw_rd_mem_read", bus.mem_read, 1'b1);
            chk1("rmw_rd_mem_write", bus.mem_write, 1'b0);
            @(negedge clk);
            #1;
            model_store(f3, a, d);
            chk1("rmw_wr_stall", bus.stall, 1'b0);
            chk1("rmw_wr_mem_write", bus.mem_write, 1'b1);
            chk("rmw_wr_data", bus.mem_write_data, model_word(a));
            chk("rmw_wr_addr", bus.mem_addr, {a[31:2], 2'b00});
            wr = bus.mem_write_data;
        end
    endtask

    task automatic do_fault(input logic w, input logic [2:0] f3,
                            input logic [31:0] a, input string tag);
        @(negedge clk);
        drive(1'b1, w, f3, a, 32'hDEAD_BEEF);
        #1;
        chk1({tag, "_fault"}, bus.fault, 1'b1);
        chk1({tag, "_mem_read"}, bus.mem_read, 1'b0);
        chk1({tag, "_mem_write"}, bus.mem_write, 1'b0);
        chk1({tag, "_ld_valid"}, bus.load_valid, 1'b0);
        chk1({tag, "_stall"}, bus.stall, 1'b0);
    endtask

    initial begin
        logic [31:0] obs;
        logic [31:0] a;
        logic [2:0]  f3;
        int          sel;

        bus.fault_clr = 1'b0;
        drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        chk1("rst_stall", bus.stall, 1'b0);
        chk1("rst_mem_read", bus.mem_read, 1'b0);
        chk1("rst_mem_write", bus.mem_write, 1'b0);
        chk1("rst_ld_valid", bus.load_valid, 1'b0);
        chk1("rst_fault", bus.fault, 1'b0);
        chk1("rst_sticky", bus.fault_sticky, 1'b0);
        chk("rst_mem_addr", bus.mem_addr, 32'h0);
        chk("rst_ld_data", bus.load_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            preload(10'(i * 4), $urandom);
        end

        // Lane extraction and extension.
        preload(10'h10, 32'h8040_20F1);
        do_load(3'b000, 32'h10, obs);
        chk("lb_10", obs, 32'hFFFF_FFF1);
        do_load(3'b100, 32'h13, obs);
        chk("lbu_13", obs, 32'h0000_0080);
        do_load(3'b001, 32'h12, obs);
        chk("lh_12", obs, 32'hFFFF_8040);
        do_load(3'b101, 32'h10, obs);
        chk("lhu_10", obs, 32'h0000_20F1);
        do_load(3'b010, 32'h10, obs);
        chk("lw_10", obs, 32'h8040_20F1);

        // Byte and half RMW, then back-to-back SW.
        preload(10'h20, 32'h1122_3344);
        do_store(3'b000, 32'h21, 32'h0000_00AB, obs);
        chk("sb_21_word", obs, 32'h1122_AB44);
        do_load(3'b010, 32'h20, obs);
        chk("lw_20_sb", obs, 32'h1122_AB44);
        do_store(3'b001, 32'h22, 32'h0000_BEEF, obs);
        chk("sh_22_word", obs, 32'hBEEF_AB44);
        do_store(3'b010, 32'h24, 32'h5566_7788, obs);
        do_load(3'b010, 32'h20, obs);
        chk("lw_20_sh", obs, 32'hBEEF_AB44);
        do_load(3'b010, 32'h24, obs);
        chk("lw_24_sw", obs, 32'h5566_7788);

        // Faults and the sticky flag.
        do_fault(1'b0, 3'b010, 32'h22, "lw_mis");
        do_idle();
        chk1("sticky_set", bus.fault_sticky, 1'b1);
        chk1("fault_pulse_end", bus.fault, 1'b0);
        do_fault(1'b1, 3'b010, 32'h400, "sw_oor");
        do_load(3'b010, 32'h0, obs);
        do_fault(1'b0, 3'b001, 32'h3FF, "lh_mis_top");
        do_fault(1'b0, 3'b000, 32'h400, "lb_oor");
        do_fault(1'b0, 3'b010, 32'hFFFF_FFFC, "lw_wrap");
        do_fault(1'b0, 3'b011, 32'h10, "ld_ill");
        do_fault(1'b1, 3'b100, 32'h10, "st_ill");
        do_fault(1'b1, 3'b001, 32'h21, "sh_mis");
        do_load(3'b100, 32'h3FF, obs);
        do_store(3'b010, 32'h3FC, 32'hA5A5_5A5A, obs);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        #1;
        chk1("sticky_clr", bus.fault_sticky, 1'b0);
        do_fault(1'b0, 3'b010, 32'h22, "lw_mis_clr");
        bus.fault_clr = 1'b1;
        do_idle();
        bus.fault_clr = 1'b0;
        chk1("sticky_fault_wins", bus.fault_sticky, 1'b1);
        bus.fault_clr = 1'b1;
        do_idle();
        bus.fault_clr = 1'b0;

        // Reset during the write half of an RMW.
        preload(10'h30, 32'hCAFE_BABE);
        @(negedge clk);
        drive(1'b1, 1'b1, 3'b000, 32'h31, 32'h0000_0055);
        #1;
        chk1("rst_rmw_stall", bus.stall, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("rst_rmw_mem_write", bus.mem_write, 1'b0);
        chk1("rst_rmw_stall2", bus.stall, 1'b0);
        chk1("rst_rmw_mem_read", bus.mem_read, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        rst_n = 1'b1;
        do_load(3'b010, 32'h30, obs);
        chk("lw_30_after_rst", obs, 32'hCAFE_BABE);

        // Random loads/stores against the reference model.
        for (int n = 0; n < 10000; n++) begin
            sel = $urandom_range(0, 7);
            case (sel)
                0: f3 = 3'b000;
                1: f3 = 3'b001;
                2: f3 = 3'b010;
                3: f3 = 3'b100;
                4: f3 = 3'b101;
                5: f3 = 3'b000;
                6: f3 = 3'b001;
                default: f3 = 3'b010;
            endcase
            a = 32'($urandom_range(0, 1023));
            if (f3[1:0] == 2'b01) a[0] = 1'b0;
            if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
            if (sel < 5) begin
                do_load(f3, a, obs);
            end else begin
                do_store(f3, a, $urandom, obs);
            end
            if ((n % 16) == 15) do_idle();
        end

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
